// File: rtl/axi4lite_dpc_config_master.sv
// AXI4-Lite master that programs the defect-pixel-correction register block:
// control/count/threshold writes, bad-pixel table upload from a local ROM, then a readback check.
module axi4lite_dpc_config_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int LUT_INDEX_WIDTH    = 8,
  parameter int AXIS_TDATA_WIDTH   = 24,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESET,
  input  logic                              start,
  input  logic [LUT_INDEX_WIDTH-1:0]        manual_bp_num,
  input  logic [AXIS_TDATA_WIDTH-1:0]       k_threshold,
  output logic [LUT_INDEX_WIDTH-1:0]        tbl_addr,
  input  logic [31:0]                       tbl_rdata,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int LW = LUT_INDEX_WIDTH;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  // state       | meaning
  // S_IDLE      | waiting for start
  // S_FETCH     | table ROM addressed, data captured on the second cycle
  // S_WRITE     | AW/W valid, each dropping on its own ready
  // S_WRESP     | waiting for B
  // S_READ      | AR valid on reg0
  // S_RRESP_WAIT| waiting for R, checks the enable bit
  // S_FINISH    | one-cycle wrap-up, busy already low
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WRITE, S_WRESP, S_READ, S_RRESP_WAIT, S_FINISH
  } state_t;

  typedef enum logic [2:0] {
    PH_CLR, PH_NUM, PH_THR, PH_TBL, PH_SET
  } phase_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  phase_t                     r_phase;
  logic [LW-1:0]              r_n;
  logic [AXIS_TDATA_WIDTH-1:0] r_k;
  logic [LW-1:0]              r_idx;
  logic [LW-1:0]              r_tbl_addr;
  logic                       r_fetch_rdy;
  logic [AW-1:0]              r_awaddr;
  logic [DW-1:0]              r_wdata;
  logic [AW-1:0]              r_araddr;
  logic                       r_awvalid;
  logic                       r_wvalid;
  logic                       r_done;
  logic                       r_error;

  logic                       w_aw_ok;
  logic                       w_w_ok;
  logic                       w_tbl_done;
  logic [LW-1:0]              w_idx_nxt;
  logic [AW-1:0]              w_addr_tbl;
  logic                       w_rd_ok;
  logic                       w_unused_rdata;

  assign w_aw_ok    = !r_awvalid || M_AXI_AWREADY;
  assign w_w_ok     = !r_wvalid  || M_AXI_WREADY;
  // Coming out of the threshold write the "last entry" question is whether the table is empty.
  assign w_tbl_done = (r_phase == PH_THR) ? (r_n == '0) : (r_idx == r_n - LW'(1));
  assign w_idx_nxt  = (r_phase == PH_THR) ? '0 : r_idx + LW'(1);
  assign w_addr_tbl = BASE_ADDR + ((AW'(r_idx) + AW'(4)) << 2);
  assign w_rd_ok    = (M_AXI_RRESP == RESP_OKAY) && M_AXI_RDATA[0];
  assign w_unused_rdata = ^M_AXI_RDATA[DW-1:1];

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:       if (start) w_state_nxt = S_WRITE;
      S_FETCH:      if (r_fetch_rdy) w_state_nxt = S_WRITE;
      S_WRITE:      if (w_aw_ok && w_w_ok) w_state_nxt = S_WRESP;
      S_WRESP: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != RESP_OKAY) begin
            w_state_nxt = S_FINISH;
          end else begin
            case (r_phase)
              PH_CLR, PH_NUM: w_state_nxt = S_WRITE;
              PH_THR, PH_TBL: w_state_nxt = w_tbl_done ? S_WRITE : S_FETCH;
              default:        w_state_nxt = S_READ;
            endcase
          end
        end
      end
      S_READ:       if (M_AXI_ARREADY) w_state_nxt = S_RRESP_WAIT;
      S_RRESP_WAIT: if (M_AXI_RVALID) w_state_nxt = S_FINISH;
      S_FINISH:     w_state_nxt = S_IDLE;
      default:      w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      r_phase     <= PH_CLR;
      r_n         <= '0;
      r_k         <= '0;
      r_idx       <= '0;
      r_tbl_addr  <= '0;
      r_fetch_rdy <= 1'b0;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_araddr    <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n       <= manual_bp_num;
            r_k       <= k_threshold;
            r_phase   <= PH_CLR;
            r_idx     <= '0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_awaddr  <= BASE_ADDR;
            r_wdata   <= '0;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (!r_fetch_rdy) begin
            r_fetch_rdy <= 1'b1;
          end else begin
            r_wdata   <= DW'(tbl_rdata);
            r_awaddr  <= w_addr_tbl;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
          end
        end
        S_WRITE: begin
          if (M_AXI_AWREADY) r_awvalid <= 1'b0;
          if (M_AXI_WREADY)  r_wvalid  <= 1'b0;
        end
        S_WRESP: begin
          if (M_AXI_BVALID) begin
            if (M_AXI_BRESP != RESP_OKAY) begin
              r_error <= 1'b1;
            end else begin
              case (r_phase)
                PH_CLR: begin
                  r_phase   <= PH_NUM;
                  r_awaddr  <= BASE_ADDR + AW'(4);
                  r_wdata   <= DW'(r_n);
                  r_awvalid <= 1'b1;
                  r_wvalid  <= 1'b1;
                end
                PH_NUM: begin
                  r_phase   <= PH_THR;
                  r_awaddr  <= BASE_ADDR + AW'(8);
                  r_wdata   <= DW'(r_k);
                  r_awvalid <= 1'b1;
                  r_wvalid  <= 1'b1;
                end
                PH_THR, PH_TBL: begin
                  if (w_tbl_done) begin
                    r_phase   <= PH_SET;
                    r_awaddr  <= BASE_ADDR;
                    r_wdata   <= DW'(1);
                    r_awvalid <= 1'b1;
                    r_wvalid  <= 1'b1;
                  end else begin
                    r_phase     <= PH_TBL;
                    r_idx       <= w_idx_nxt;
                    r_tbl_addr  <= w_idx_nxt;
                    r_fetch_rdy <= 1'b0;
                  end
                end
                default: r_araddr <= BASE_ADDR;
              endcase
            end
          end
        end
        S_RRESP_WAIT: begin
          if (M_AXI_RVALID) begin
            if (w_rd_ok) r_done  <= 1'b1;
            else         r_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign tbl_addr      = r_tbl_addr;
  assign busy          = (r_state != S_IDLE) && (r_state != S_FINISH);
  assign done          = r_done;
  assign error         = r_error;
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = (r_state == S_WRESP);
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = (r_state == S_READ);
  assign M_AXI_RREADY  = (r_state == S_RRESP_WAIT);

endmodule

// File: tb/tb_axi4lite_dpc_config_master.sv
// Bench for axi4lite_dpc_config_master: randomized AXI4-Lite slave and table ROM,
// expected write/read traffic derived from the configuration rules.
module tb_axi4lite_dpc_config_master;
  localparam logic [31:0] BASE = 32'h4000_0100;

  logic        clk, rst, start;
  logic [7:0]  manual_bp_num;
  logic [23:0] k_threshold;
  logic [7:0]  tbl_addr;
  logic [31:0] tbl_rdata;
  logic        busy, done, error;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;

  int checks = 0;
  int errors = 0;

  axi4lite_dpc_config_master #(.BASE_ADDR(BASE)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .start(start),
    .manual_bp_num(manual_bp_num), .k_threshold(k_threshold),
    .tbl_addr(tbl_addr), .tbl_rdata(tbl_rdata),
    .busy(busy), .done(done), .error(error),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // slave configuration and logs
  int aw_min = 0, aw_max = 0, w_min = 0, w_max = 0, ar_min = 0, ar_max = 0;
  int aw_wait = 0, w_wait = 0, ar_wait = 0;
  int err_idx = -1;
  logic [31:0] rb_val = 32'h1;
  logic [31:0] awq[$], wq[$];
  logic [31:0] wr_addr[$], wr_data[$];
  int b_pend = 0, r_pend = 0, b_consumed = 0, n_reads = 0;
  bit b_hs = 0, r_hs = 0;
  logic [31:0] rd_addr_log = '0;
  // monitor
  int viol = 0, tbl_changes = 0;
  bit saw_split = 0;
  bit prev_awv = 0, prev_wv = 0;
  logic [31:0] prev_awaddr = '0, prev_wdata = '0;
  logic [7:0] prev_tbl = '0;
  // table ROM with one cycle of read latency
  logic [31:0] rom [256];
  logic [7:0] addr_d = '0;

  function automatic int rdly(input int lo, input int hi);
    if (hi <= lo) return lo;
    return int'($urandom_range(hi, lo));
  endfunction

  always @(negedge clk) begin
    tbl_rdata = rom[addr_d];
    addr_d = tbl_addr;
    if (rst) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      bresp = 0; rresp = 0; rdata = 0;
      b_hs = 0; r_hs = 0; b_pend = 0; r_pend = 0;
      awq.delete(); wq.delete();
      prev_awv = 0; prev_wv = 0; prev_tbl = tbl_addr;
    end else begin
      // protocol monitor, using the ready values driven during the cycle just ended
      if (prev_awv && !awready && (!awvalid || awaddr !== prev_awaddr)) viol++;
      if (prev_wv && !wready && (!wvalid || wdata !== prev_wdata)) viol++;
      if (arvalid && (awvalid || wvalid || (bvalid && !b_hs) || b_pend > 0 || awq.size() > 0 || wq.size() > 0)) viol++;
      if (awvalid && (arvalid || (rvalid && !r_hs) || r_pend > 0 || (bvalid && !b_hs))) viol++;
      if (wstrb !== 4'hF || awprot !== 3'b0 || arprot !== 3'b0) viol++;
      if (awvalid && !wvalid && prev_wv) saw_split = 1;
      if (tbl_addr !== prev_tbl) tbl_changes++;
      prev_tbl = tbl_addr;
      // B channel
      if (b_hs) begin bvalid = 0; b_hs = 0; b_consumed++; end
      if (!bvalid && b_pend > 0) begin
        bvalid = 1; bresp = (b_consumed == err_idx) ? 2'b10 : 2'b00; b_pend--;
      end
      b_hs = bvalid && bready;
      // R channel
      if (r_hs) begin rvalid = 0; r_hs = 0; end
      if (!rvalid && r_pend > 0) begin rvalid = 1; rdata = rb_val; rresp = 2'b00; r_pend--; end
      r_hs = rvalid && rready;
      // AW / W / AR acceptance; a ready decided here completes at the next rising edge
      awready = 0;
      if (awvalid) begin
        if (aw_wait == 0) begin awready = 1; awq.push_back(awaddr); aw_wait = rdly(aw_min, aw_max); end
        else aw_wait--;
      end
      wready = 0;
      if (wvalid) begin
        if (w_wait == 0) begin wready = 1; wq.push_back(wdata); w_wait = rdly(w_min, w_max); end
        else w_wait--;
      end
      if (awq.size() > 0 && wq.size() > 0) begin
        wr_addr.push_back(awq.pop_front()); wr_data.push_back(wq.pop_front()); b_pend++;
      end
      arready = 0;
      if (arvalid) begin
        if (ar_wait == 0) begin
          arready = 1; rd_addr_log = araddr; n_reads++; r_pend++; ar_wait = rdly(ar_min, ar_max);
        end else ar_wait--;
      end
      prev_awv = awvalid; prev_awaddr = awaddr;
      prev_wv = wvalid; prev_wdata = wdata;
    end
  end

  // reference model: the register writes a configuration run must produce
  logic [31:0] exp_addr[$], exp_data[$];
  int exp_reads;
  bit exp_done;

  task automatic model(input int n, input logic [23:0] k, input int err, input logic [31:0] rb);
    exp_addr.delete(); exp_data.delete();
    exp_addr.push_back(BASE);       exp_data.push_back(32'd0);
    exp_addr.push_back(BASE + 4);   exp_data.push_back(32'(n));
    exp_addr.push_back(BASE + 8);   exp_data.push_back({8'h00, k});
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(BASE + 32'(16 + 4 * i)); exp_data.push_back(rom[i]);
    end
    exp_addr.push_back(BASE);       exp_data.push_back(32'd1);
    if (err >= 0) begin
      while (exp_addr.size() > err + 1) begin
        void'(exp_addr.pop_back()); void'(exp_data.pop_back());
      end
    end
    exp_reads = (err >= 0) ? 0 : 1;
    exp_done  = (err < 0) && rb[0];
  endtask

  // index of the first write that differs from the model, -1 when the lists agree
  function automatic int first_diff();
    int m;
    m = (wr_addr.size() < exp_addr.size()) ? wr_addr.size() : exp_addr.size();
    for (int i = 0; i < m; i++)
      if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) return i;
    if (wr_addr.size() != exp_addr.size()) return m;
    return -1;
  endfunction

  task automatic run_seq(input int n, input logic [23:0] k, input int err, input logic [31:0] rb,
                         input bit poke, output logic [2:0] post_start, output bit timed_out);
    wr_addr.delete(); wr_data.delete();
    n_reads = 0; b_consumed = 0; err_idx = err; rb_val = rb;
    viol = 0; saw_split = 0; tbl_changes = 0; rd_addr_log = '0;
    aw_wait = rdly(aw_min, aw_max); w_wait = rdly(w_min, w_max); ar_wait = rdly(ar_min, ar_max);
    model(n, k, err, rb);
    @(negedge clk);
    manual_bp_num = 8'(n); k_threshold = k; start = 1;
    @(negedge clk);
    start = 0; manual_bp_num = 8'($urandom); k_threshold = 24'($urandom);
    post_start = {busy, done, error};
    timed_out = 1;
    for (int c = 0; c < 20000; c++) begin
      if (!busy && (done || error)) begin timed_out = 0; break; end
      start = poke && (c == 6);
      @(negedge clk);
    end
    start = 0;
  endtask

  task automatic test_reset();
    rst = 1; start = 0; manual_bp_num = 0; k_threshold = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0)
      begin errors++; $display("FAIL reset_handshake: got %b expected 00000", {awvalid, wvalid, arvalid, bready, rready}); end
    checks++;
    if ({busy, done, error} !== 3'b0)
      begin errors++; $display("FAIL reset_status: got %b expected 000", {busy, done, error}); end
    checks++;
    if ({tbl_addr, awaddr, wdata, araddr} !== '0)
      begin errors++; $display("FAIL reset_regs: tbl_addr %h awaddr %h wdata %h araddr %h expected all 0", tbl_addr, awaddr, wdata, araddr); end
    rst = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, error, awvalid, arvalid} !== 5'b0)
      begin errors++; $display("FAIL reset_release_idle: got %b expected 00000", {busy, done, error, awvalid, arvalid}); end
  endtask

  task automatic test_basic();
    logic [2:0] ps; bit to; int d;
    aw_min = 0; aw_max = 0; w_min = 0; w_max = 0; ar_min = 0; ar_max = 0;
    run_seq(3, 24'h000123, -1, 32'h1, 1, ps, to);
    checks++;
    if (to) begin errors++; $display("FAIL basic_timeout: sequence did not finish"); end
    checks++;
    if (ps !== 3'b100) begin errors++; $display("FAIL basic_start_status: busy/done/error got %b expected 100", ps); end
    d = first_diff();
    checks++;
    if (d !== -1) begin errors++; $display("FAIL basic_writes: first difference at write %0d, got %0d writes expected %0d", d, wr_addr.size(), exp_addr.size()); end
    checks++;
    if (n_reads !== 1 || rd_addr_log !== BASE)
      begin errors++; $display("FAIL basic_read: got %0d reads at %h expected 1 at %h", n_reads, rd_addr_log, BASE); end
    checks++;
    if ({busy, done, error} !== 3'b010) begin errors++; $display("FAIL basic_status: got %b expected 010", {busy, done, error}); end
    checks++;
    if (viol !== 0 || b_consumed !== 7) begin errors++; $display("FAIL basic_protocol: violations %0d B %0d expected 0 and 7", viol, b_consumed); end
  endtask

  task automatic test_zero_entries();
    logic [2:0] ps; bit to; int d;
    run_seq(0, 24'hABCDEF, -1, 32'h1, 0, ps, to);
    d = first_diff();
    checks++;
    if (to || d !== -1) begin errors++; $display("FAIL zero_writes: timeout %0d diff at %0d, got %0d writes expected 4", to, d, wr_addr.size()); end
    checks++;
    if (tbl_changes !== 0) begin errors++; $display("FAIL zero_tbl_addr: got %0d tbl_addr changes expected 0", tbl_changes); end
    checks++;
    if (n_reads !== 1 || done !== 1'b1) begin errors++; $display("FAIL zero_read: reads %0d done %b expected 1 and 1", n_reads, done); end
  endtask

  task automatic test_aw_delay();
    logic [2:0] ps; bit to; int d;
    aw_min = 3; aw_max = 3; w_min = 0; w_max = 0;
    run_seq(2, 24'($urandom), -1, 32'h1, 0, ps, to);
    aw_min = 0; aw_max = 0;
    checks++;
    if (!saw_split) begin errors++; $display("FAIL awdelay_split: got no W-dropped/AW-held cycle expected at least one"); end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL awdelay_stable: got %0d protocol violations expected 0", viol); end
    d = first_diff();
    checks++;
    if (to || d !== -1 || b_consumed !== exp_addr.size())
      begin errors++; $display("FAIL awdelay_writes: diff %0d B consumed %0d expected %0d", d, b_consumed, exp_addr.size()); end
  endtask

  task automatic test_slverr();
    logic [2:0] ps; bit to; int d; int nw;
    run_seq(4, 24'($urandom), 2, 32'h1, 0, ps, to);
    d = first_diff();
    checks++;
    if (to || d !== -1) begin errors++; $display("FAIL slverr_writes: diff %0d got %0d writes expected 3", d, wr_addr.size()); end
    checks++;
    if ({busy, done, error} !== 3'b001) begin errors++; $display("FAIL slverr_status: got %b expected 001", {busy, done, error}); end
    nw = wr_addr.size();
    repeat (10) @(negedge clk);
    checks++;
    if (wr_addr.size() !== nw || n_reads !== 0 || awvalid || arvalid)
      begin errors++; $display("FAIL slverr_quiet: writes %0d->%0d reads %0d expected no further traffic", nw, wr_addr.size(), n_reads); end
  endtask

  task automatic test_readback_zero();
    logic [2:0] ps; bit to; int d;
    run_seq(1, 24'($urandom), -1, 32'h0, 0, ps, to);
    checks++;
    if (to || {done, error} !== 2'b01) begin errors++; $display("FAIL rb0_status: done/error got %b expected 01", {done, error}); end
    run_seq(2, 24'($urandom), -1, 32'h1, 0, ps, to);
    checks++;
    if (ps !== 3'b100) begin errors++; $display("FAIL rb0_restart_clear: busy/done/error got %b expected 100", ps); end
    d = first_diff();
    checks++;
    if (to || d !== -1 || {done, error} !== 2'b10)
      begin errors++; $display("FAIL rb0_rerun: diff %0d done/error %b expected -1 and 10", d, {done, error}); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] ps; bit to; bit found; int d;
    wr_addr.delete(); wr_data.delete(); b_consumed = 0; err_idx = -1;
    @(negedge clk);
    manual_bp_num = 8'd3; k_threshold = 24'h55AA; start = 1;
    @(negedge clk);
    start = 0;
    found = 0;
    for (int c = 0; c < 2000; c++) begin
      if (bready && wr_addr.size() == 5) begin found = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rstmid_reach: table entry 1 response never reached"); end
    rst = 1;
    #1;
    checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, busy, done, error} !== 8'b0 || {tbl_addr, awaddr, wdata, araddr} !== '0)
      begin errors++; $display("FAIL rstmid_outputs: ctl %b tbl_addr %h awaddr %h wdata %h expected all 0",
        {awvalid, wvalid, arvalid, bready, rready, busy, done, error}, tbl_addr, awaddr, wdata); end
    repeat (2) @(negedge clk);
    rst = 0;
    run_seq(2, 24'h000777, -1, 32'h1, 0, ps, to);
    d = first_diff();
    checks++;
    if (to || d !== -1) begin errors++; $display("FAIL rstmid_restart: diff at %0d first addr %h expected %h data 0", d, (wr_addr.size() > 0) ? wr_addr[0] : 32'hx, BASE); end
  endtask

  task automatic test_random();
    logic [2:0] ps; bit to; int d; int n; int err; logic [31:0] rb;
    for (int it = 0; it < 8; it++) begin
      aw_max = int'($urandom_range(3, 0)); w_max = int'($urandom_range(3, 0)); ar_max = int'($urandom_range(2, 0));
      n   = (it == 7) ? 255 : int'($urandom_range(12, 0));
      if (it == 7) begin aw_max = 0; w_max = 0; end
      err = ($urandom_range(3, 0) == 0) ? int'($urandom_range(n + 3, 0)) : -1;
      rb  = (it == 7) ? 32'h1 : $urandom;
      for (int i = 0; i < 256; i++) rom[i] = $urandom;
      run_seq(n, 24'($urandom), err, rb, it[0], ps, to);
      d = first_diff();
      checks++;
      if (to || d !== -1) begin errors++; $display("FAIL random_writes[%0d]: N=%0d err=%0d diff %0d got %0d writes expected %0d", it, n, err, d, wr_addr.size(), exp_addr.size()); end
      checks++;
      if (n_reads !== exp_reads || {done, error} !== {exp_done, !exp_done})
        begin errors++; $display("FAIL random_result[%0d]: reads %0d done/error %b expected %0d %b", it, n_reads, {done, error}, exp_reads, {exp_done, !exp_done}); end
      checks++;
      if (viol !== 0 || busy !== 1'b0) begin errors++; $display("FAIL random_protocol[%0d]: violations %0d busy %b expected 0 0", it, viol, busy); end
    end
    aw_max = 0; w_max = 0; ar_max = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    test_reset();
    test_basic();
    test_zero_entries();
    test_aw_delay();
    test_slverr();
    test_readback_zero();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
